// File: rtl/usb_fs_in_pe.sv
// usb_fs_in_pe: USB full-speed IN protocol engine with per-endpoint packet buffers.
// Optional host-handshake timeout in WAIT_ACK: define USB_FS_IN_PE_ACK_TIMEOUT_EN.
module usb_fs_in_pe #(
  parameter int NUM_IN_EPS         = 1,
  parameter int MAX_IN_PACKET_SIZE = 32,
  parameter int ACK_TIMEOUT        = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IN_EPS-1:0] reset_ep,
  input  logic [6:0]            dev_addr,
  input  logic                  bit_strobe,
  output logic [NUM_IN_EPS-1:0] in_ep_data_free,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
  input  logic [7:0]            in_ep_data,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
  input  logic [NUM_IN_EPS-1:0] in_ep_stall,
  output logic [NUM_IN_EPS-1:0] in_ep_acked,
  input  logic                  rx_pkt_start,
  input  logic                  rx_pkt_end,
  input  logic                  rx_pkt_valid,
  input  logic [3:0]            rx_pid,
  input  logic [6:0]            rx_addr,
  input  logic [3:0]            rx_endp,
  output logic                  tx_pkt_start,
  output logic [3:0]            tx_pid,
  input  logic                  tx_pkt_end,
  output logic                  tx_data_avail,
  input  logic                  tx_data_get,
  output logic [7:0]            tx_data
);

  localparam int PW = $clog2(MAX_IN_PACKET_SIZE);
  localparam int EW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
  localparam logic [6:0] MAX_CNT = 7'(MAX_IN_PACKET_SIZE);

  typedef enum logic [1:0] {
    EP_FILLING, EP_READY, EP_STALL
  } ep_state_t;

  typedef enum logic [1:0] {
    IDLE, RCVD_IN, SEND_DATA, WAIT_ACK
  } xfr_state_t;

  ep_state_t ep_q [NUM_IN_EPS];
  ep_state_t ep_d [NUM_IN_EPS];
  logic [6:0] cnt_q [NUM_IN_EPS];
  logic [7:0] buf_q [NUM_IN_EPS][MAX_IN_PACKET_SIZE];
  logic [NUM_IN_EPS-1:0] toggle_q;

  xfr_state_t xfr_q, xfr_d;
  logic [EW-1:0] endp_q, endp_d;
  logic [6:0] get_q, get_d;

  logic tok_ok, in_token, setup_token, ack_rcvd;
  logic [NUM_IN_EPS-1:0] setup_ep, cur_sel, ack_ep;
  logic abort, timeout;

  ep_state_t cur_state;
  logic [6:0] cur_cnt;
  logic cur_toggle;
  logic [7:0] cur_byte;
  logic avail;

  assign tok_ok = rx_pkt_end & rx_pkt_valid
                & (rx_addr == dev_addr)
                & ({1'b0, rx_endp} < 5'(NUM_IN_EPS));
  assign in_token    = tok_ok & (rx_pid == 4'b1001);
  assign setup_token = tok_ok & (rx_pid == 4'b1101);
  assign ack_rcvd    = rx_pkt_end & rx_pkt_valid
                     & (rx_pid == 4'b0010);

  always_comb begin
    setup_ep = '0;
    cur_sel  = '0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      setup_ep[i] = setup_token & (rx_endp == 4'(i));
      cur_sel[i]  = (endp_q == EW'(i));
    end
  end

  always_comb begin
    cur_state  = EP_FILLING;
    cur_cnt    = '0;
    cur_toggle = 1'b0;
    cur_byte   = '0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (cur_sel[i]) begin
        cur_state  = ep_q[i];
        cur_cnt    = cnt_q[i];
        cur_toggle = toggle_q[i];
        cur_byte   = buf_q[i][get_q[PW-1:0]];
      end
    end
  end

  // A reset or SETUP aimed at the endpoint in flight kills the transfer.
  assign abort = reset
               | ((xfr_q != IDLE)
                  & (|((reset_ep | setup_ep) & cur_sel)));

  assign avail = (xfr_q == SEND_DATA) & (get_q < cur_cnt);
  assign tx_data_avail = avail;
  assign tx_data = avail ? cur_byte : 8'h00;

`ifdef USB_FS_IN_PE_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_q;

  always_ff @(posedge clk) begin
    if (reset || xfr_q != WAIT_ACK || rx_pkt_start)
      to_q <= '0;
    else if (bit_strobe && !timeout)
      to_q <= to_q + 1'b1;
  end

  assign timeout = (to_q == TW'(ACK_TIMEOUT));
`else
  logic unused_to;
  assign unused_to = ^{bit_strobe, rx_pkt_start, 8'(ACK_TIMEOUT)};
  assign timeout = 1'b0;
`endif

  always_comb begin
    xfr_d        = xfr_q;
    endp_d       = endp_q;
    get_d        = get_q;
    tx_pkt_start = 1'b0;
    tx_pid       = 4'b0000;
    ack_ep       = '0;
    if (abort) begin
      xfr_d = IDLE;
    end else begin
      unique case (xfr_q)
        IDLE: begin
          if (in_token) begin
            xfr_d  = RCVD_IN;
            endp_d = rx_endp[EW-1:0];
          end
        end
        RCVD_IN: begin
          tx_pkt_start = 1'b1;
          xfr_d = IDLE;
          unique case (1'b1)
            cur_state == EP_STALL:   tx_pid = 4'b1110;
            cur_state == EP_FILLING: tx_pid = 4'b1010;
            cur_state == EP_READY: begin
              tx_pid = {cur_toggle, 3'b011};
              get_d  = '0;
              xfr_d  = SEND_DATA;
            end
            default: tx_pid = 4'b1010;
          endcase
        end
        SEND_DATA: begin
          if (tx_data_get && avail)
            get_d = get_q + 7'd1;
          if (tx_pkt_end)
            xfr_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (in_token) begin
            xfr_d  = RCVD_IN;
            endp_d = rx_endp[EW-1:0];
          end else if (rx_pkt_end) begin
            if (ack_rcvd)
              ack_ep = cur_sel;
            xfr_d = IDLE;
          end else if (timeout) begin
            xfr_d = IDLE;
          end
        end
        default: xfr_d = IDLE;
      endcase
    end
  end

  assign in_ep_acked = ack_ep;

  always_ff @(posedge clk) begin
    if (reset) begin
      xfr_q  <= IDLE;
      endp_q <= '0;
      get_q  <= '0;
    end else begin
      xfr_q  <= xfr_d;
      endp_q <= endp_d;
      get_q  <= get_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      ep_d[i] = ep_q[i];
      in_ep_data_free[i] = (ep_q[i] == EP_FILLING);
      if (in_ep_stall[i]) begin
        ep_d[i] = EP_STALL;
      end else begin
        unique case (ep_q[i])
          EP_FILLING: if (in_ep_data_done[i]) ep_d[i] = EP_READY;
          EP_READY:   if (ack_ep[i])          ep_d[i] = EP_FILLING;
          EP_STALL:   if (setup_ep[i])        ep_d[i] = EP_FILLING;
          default:                            ep_d[i] = EP_FILLING;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (reset || reset_ep[i]) begin
        ep_q[i]     <= EP_FILLING;
        cnt_q[i]    <= '0;
        toggle_q[i] <= 1'b0;
      end else begin
        ep_q[i] <= ep_d[i];
        if (ep_d[i] == EP_FILLING && ep_q[i] != EP_FILLING)
          cnt_q[i] <= '0;
        else if (in_ep_data_put[i] && ep_q[i] == EP_FILLING
                 && cnt_q[i] < MAX_CNT)
          cnt_q[i] <= cnt_q[i] + 7'd1;
        if (setup_ep[i])
          toggle_q[i] <= 1'b1;
        else if (ack_ep[i])
          toggle_q[i] <= ~toggle_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (!reset && !reset_ep[i] && in_ep_data_put[i]
          && ep_q[i] == EP_FILLING && cnt_q[i] < MAX_CNT)
        buf_q[i][cnt_q[i][PW-1:0]] <= in_ep_data;
    end
  end

endmodule

// File: tb/tb_usb_fs_in_pe.sv
// tb_usb_fs_in_pe: directed vector bench for usb_fs_in_pe (NUM_IN_EPS=1, MAX=32).
// Build with +define+USB_FS_IN_PE_ACK_TIMEOUT_EN to exercise the handshake timeout.
module tb_usb_fs_in_pe;

  localparam logic [6:0] DEV = 7'h2A;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  logic clk = 1'b0;
  logic reset;
  logic [0:0] reset_ep;
  logic [6:0] dev_addr;
  logic bit_strobe;
  logic [0:0] in_ep_data_free;
  logic [0:0] in_ep_data_put;
  logic [7:0] in_ep_data;
  logic [0:0] in_ep_data_done;
  logic [0:0] in_ep_stall;
  logic [0:0] in_ep_acked;
  logic rx_pkt_start, rx_pkt_end, rx_pkt_valid;
  logic [3:0] rx_pid;
  logic [6:0] rx_addr;
  logic [3:0] rx_endp;
  logic tx_pkt_start;
  logic [3:0] tx_pid;
  logic tx_pkt_end;
  logic tx_data_avail;
  logic tx_data_get;
  logic [7:0] tx_data;

  int passed = 0;
  int total  = 0;

  usb_fs_in_pe dut (
    .clk(clk), .reset(reset), .reset_ep(reset_ep),
    .dev_addr(dev_addr), .bit_strobe(bit_strobe),
    .in_ep_data_free(in_ep_data_free),
    .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data),
    .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall),
    .in_ep_acked(in_ep_acked),
    .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end),
    .rx_pkt_valid(rx_pkt_valid), .rx_pid(rx_pid),
    .rx_addr(rx_addr), .rx_endp(rx_endp),
    .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid),
    .tx_pkt_end(tx_pkt_end), .tx_data_avail(tx_data_avail),
    .tx_data_get(tx_data_get), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         nput;
    logic [7:0] seed;
    logic [3:0] hs_pid;
    logic       hs_valid;
    logic [3:0] exp_pid;
    int         exp_len;
    logic       exp_ack;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_packet(input logic [3:0] pid, input logic valid,
                           input logic [6:0] addr, input logic [3:0] endp,
                           output logic acked);
    rx_pkt_start = 1'b1;
    tick();
    rx_pkt_start = 1'b0;
    rx_pid = pid;
    rx_pkt_valid = valid;
    rx_addr = addr;
    rx_endp = endp;
    rx_pkt_end = 1'b1;
    #1 acked = in_ep_acked[0];
    tick();
    rx_pkt_end = 1'b0;
    rx_pkt_valid = 1'b0;
    #1;
  endtask

  task automatic send_in(input logic [3:0] exp_pid);
    logic a;
    rx_packet(PID_IN, 1'b1, DEV, 4'd0, a);
    chk("tx_pkt_start", tx_pkt_start, 1);
    chk("tx_pid", tx_pid, exp_pid);
    tick();
  endtask

  task automatic put(input logic [7:0] b);
    in_ep_data = b;
    in_ep_data_put = 1'b1;
    tick();
    in_ep_data_put = 1'b0;
    #1;
  endtask

  task automatic done();
    in_ep_data_done = 1'b1;
    tick();
    in_ep_data_done = 1'b0;
    #1;
  endtask

  task automatic fill(input int n, input logic [7:0] seed);
    for (int k = 0; k < n; k++) put(8'(seed * (k + 1)));
    done();
  endtask

  task automatic read_pkt(input int len, input logic [7:0] seed);
    for (int k = 0; k < len; k++) begin
      chk("tx_data_avail", tx_data_avail, 1);
      chk("tx_data", tx_data, 8'(seed * (k + 1)));
      tx_data_get = 1'b1;
      tick();
      tx_data_get = 1'b0;
      #1;
    end
    chk("avail_end", tx_data_avail, 0);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    #1;
  endtask

  task automatic handshake(input logic [3:0] pid, input logic valid,
                           input logic exp_ack, input string name);
    logic a;
    rx_packet(pid, valid, 7'h00, 4'd0, a);
    chk(name, a, exp_ack);
  endtask

  initial begin
    logic a;
    vecs[0] = '{3,  8'h11, PID_NAK, 1'b1, 4'b0011, 3,  1'b0};
    vecs[1] = '{3,  8'h11, PID_ACK, 1'b1, 4'b1011, 3,  1'b1};
    vecs[2] = '{40, 8'h05, PID_ACK, 1'b1, 4'b0011, 32, 1'b1};
    vecs[3] = '{0,  8'h00, PID_ACK, 1'b1, 4'b1011, 0,  1'b1};
    vecs[4] = '{5,  8'h07, PID_ACK, 1'b0, 4'b0011, 5,  1'b0};
    vecs[5] = '{1,  8'hA5, PID_ACK, 1'b1, 4'b1011, 1,  1'b1};

    reset = 1'b1;
    reset_ep = '0;
    dev_addr = DEV;
    bit_strobe = 1'b0;
    in_ep_data_put = '0;
    in_ep_data = '0;
    in_ep_data_done = '0;
    in_ep_stall = '0;
    rx_pkt_start = 1'b0;
    rx_pkt_end = 1'b0;
    rx_pkt_valid = 1'b0;
    rx_pid = '0;
    rx_addr = '0;
    rx_endp = '0;
    tx_pkt_end = 1'b0;
    tx_data_get = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;

    chk("rst_free", in_ep_data_free, 1);
    chk("rst_start", tx_pkt_start, 0);
    chk("rst_pid", tx_pid, 0);
    chk("rst_avail", tx_data_avail, 0);
    chk("rst_acked", in_ep_acked, 0);
    chk("rst_data", tx_data, 0);

    send_in(PID_NAK);
    chk("nak_free", in_ep_data_free, 1);
    chk("nak_idle", tx_pkt_start, 0);

    rx_packet(PID_IN, 1'b1, 7'h11, 4'd0, a);
    chk("wrong_addr", tx_pkt_start, 0);
    rx_packet(PID_IN, 1'b1, DEV, 4'd1, a);
    chk("wrong_endp", tx_pkt_start, 0);

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].nput, vecs[v].seed);
      chk("armed_free", in_ep_data_free, 0);
      send_in(vecs[v].exp_pid);
      read_pkt(vecs[v].exp_len, vecs[v].seed);
      handshake(vecs[v].hs_pid, vecs[v].hs_valid, vecs[v].exp_ack, "acked");
      if (!vecs[v].exp_ack) begin
        chk("retry_free", in_ep_data_free, 0);
        send_in(vecs[v].exp_pid);
        read_pkt(vecs[v].exp_len, vecs[v].seed);
        handshake(PID_ACK, 1'b1, 1'b1, "retry_acked");
      end
      chk("post_free", in_ep_data_free, 1);
    end

    in_ep_stall = 1'b1;
    tick();
    chk("stall_free", in_ep_data_free, 0);
    send_in(4'b1110);
    in_ep_stall = 1'b0;
    tick();
    chk("stall_held", in_ep_data_free, 0);
    rx_packet(PID_SETUP, 1'b1, DEV, 4'd0, a);
    chk("setup_free", in_ep_data_free, 1);
    fill(1, 8'h5A);
    send_in(4'b1011);
    read_pkt(1, 8'h5A);
    handshake(PID_ACK, 1'b1, 1'b1, "setup_acked");

    fill(1, 8'h3C);
    send_in(4'b0011);
    read_pkt(1, 8'h3C);
    handshake(PID_ACK, 1'b1, 1'b1, "pre_rst_acked");

    fill(1, 8'h44);
    send_in(4'b1011);
    read_pkt(1, 8'h44);
    reset_ep = 1'b1;
    tick();
    reset_ep = 1'b0;
    #1;
    chk("rst_ep_free", in_ep_data_free, 1);
    handshake(PID_ACK, 1'b1, 1'b0, "rst_ep_acked");
    send_in(PID_NAK);
    fill(1, 8'h66);
    send_in(4'b0011);
    read_pkt(1, 8'h66);
    handshake(PID_ACK, 1'b1, 1'b1, "rst_ep_reacked");

    fill(2, 8'h0F);
    send_in(4'b1011);
    read_pkt(2, 8'h0F);
    repeat (30) begin
      bit_strobe = 1'b1;
      tick();
      bit_strobe = 1'b0;
      tick();
    end
`ifdef USB_FS_IN_PE_ACK_TIMEOUT_EN
    handshake(PID_ACK, 1'b1, 1'b0, "late_acked");
    chk("to_free", in_ep_data_free, 0);
    send_in(4'b1011);
    read_pkt(2, 8'h0F);
    handshake(PID_ACK, 1'b1, 1'b1, "to_retry_acked");
`else
    handshake(PID_ACK, 1'b1, 1'b1, "late_acked");
`endif
    chk("final_free", in_ep_data_free, 1);
    send_in(PID_NAK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
